// File: rtl/alu_opcodes_pkg.sv
// Shared encodings for the ALU sequencer: instruction classes/ext fields,
// 8-bit ALU opcodes, PSR bit positions and the sequencer FSM states.
package alu_opcodes_pkg;

  localparam logic [3:0] CLS_REG    = 4'h0;
  localparam logic [3:0] CLS_ADDI   = 4'h5;
  localparam logic [3:0] CLS_ADDUI  = 4'h6;
  localparam logic [3:0] CLS_ADDCUI = 4'h7;
  localparam logic [3:0] CLS_SHIFT  = 4'h8;
  localparam logic [3:0] CLS_SUBI   = 4'h9;
  localparam logic [3:0] CLS_CMPI   = 4'hB;

  localparam logic [3:0] EXT_NOP   = 4'h0;
  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_ADDU  = 4'h6;
  localparam logic [3:0] EXT_ADDCU = 4'h7;
  localparam logic [3:0] EXT_TEST  = 4'h8;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_NOT   = 4'hF;

  // Shift-class ext values; LSHI/RSHI carry their amount in inst[3:0].
  localparam logic [3:0] EXT_LSHI  = 4'h0;
  localparam logic [3:0] EXT_RSHI  = 4'h1;
  localparam logic [3:0] EXT_LSH   = 4'h4;
  localparam logic [3:0] EXT_ARSH  = 4'h6;
  localparam logic [3:0] EXT_RSH   = 4'hC;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_ADDU   = 8'h06;
  localparam logic [7:0] OP_ADDCU  = 8'h07;
  localparam logic [7:0] OP_TEST   = 8'h08;
  localparam logic [7:0] OP_SUB    = 8'h09;
  localparam logic [7:0] OP_CMP    = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0F;
  localparam logic [7:0] OP_ADDI   = 8'h50;
  localparam logic [7:0] OP_ADDUI  = 8'h60;
  localparam logic [7:0] OP_ADDCUI = 8'h70;
  localparam logic [7:0] OP_LSHI   = 8'h80;
  localparam logic [7:0] OP_RSHI   = 8'h81;
  localparam logic [7:0] OP_LSH    = 8'h84;
  localparam logic [7:0] OP_ARSH   = 8'h86;
  localparam logic [7:0] OP_RSH    = 8'h8C;
  localparam logic [7:0] OP_SUBI   = 8'h90;
  localparam logic [7:0] OP_CMPI   = 8'hB0;

  localparam int PSR_C = 4;
  localparam int PSR_F = 3;
  localparam int PSR_L = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } seq_state_e;

  // Compare/test style operations only report flags; NOP reports nothing.
  function automatic logic op_writes_reg(input logic [7:0] op);
    return !(op inside {OP_NOP, OP_CMP, OP_CMPI, OP_TEST});
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 16x16 register file for the sequencer: one write port, two operand read
// ports and a debug read port, all reads combinational.
module seq_regfile
  import alu_opcodes_pkg::*;
#(
  parameter int REGS  = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       raddr_a,
  input  logic [3:0]       raddr_b,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem [REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for an external combinational ALU: accepts
// instruction words, drives opcode/operands, and retires results into regs/PSR.
module alu_sequencer
  import alu_opcodes_pkg::*;
#(
  parameter int REGS  = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_inst,
  input  logic             ld_en,
  input  logic [3:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_opcode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_carry,
  input  logic             alu_flag,
  input  logic             alu_low,
  input  logic             alu_neg,
  input  logic             alu_zero,
  output logic [4:0]       psr,
  output logic             done,
  output logic             err,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  seq_state_e state, state_nxt;

  logic [15:0]      inst_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;
  logic [4:0]       psr_q;
  logic             done_q;
  logic             err_q;

  logic [3:0]       cls, rdest, ext, rsrc;
  logic [7:0]       imm8;
  logic [WIDTH-1:0] rd_val, rs_val;

  logic [7:0]       dec_op;
  logic [WIDTH-1:0] dec_b;
  logic             dec_illegal;
  logic             dec_writes;
  logic             dec_flags;
  logic             alu_busy;

  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  assign cls   = inst_q[15:12];
  assign rdest = inst_q[11:8];
  assign ext   = inst_q[7:4];
  assign rsrc  = inst_q[3:0];
  assign imm8  = inst_q[7:0];

  seq_regfile #(
    .REGS  (REGS),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr_a  (rdest),
    .raddr_b  (rsrc),
    .dbg_addr (dbg_addr),
    .rdata_a  (rd_val),
    .rdata_b  (rs_val),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !ld_en;
        if (in_valid && !ld_en) begin
          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoder works from the latched word, so operands stay put through EXEC.
  always_comb begin
    dec_op      = OP_NOP;
    dec_b       = rs_val;
    dec_illegal = 1'b0;
    case (cls)
      CLS_REG: begin
        case (ext)
          EXT_NOP, EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU, EXT_ADDCU,
          EXT_TEST, EXT_SUB, EXT_CMP, EXT_NOT: dec_op = {CLS_REG, ext};
          default: dec_illegal = 1'b1;
        endcase
      end
      CLS_SHIFT: begin
        case (ext)
          EXT_LSH, EXT_RSH, EXT_ARSH: dec_op = {CLS_SHIFT, ext};
          EXT_LSHI, EXT_RSHI: begin
            dec_op = {CLS_SHIFT, ext};
            dec_b  = {{(WIDTH-4){1'b0}}, rsrc};
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      CLS_ADDI, CLS_SUBI, CLS_CMPI: begin
        dec_op = {cls, 4'h0};
        dec_b  = {{(WIDTH-8){imm8[7]}}, imm8};
      end
      CLS_ADDUI, CLS_ADDCUI: begin
        dec_op = {cls, 4'h0};
        dec_b  = {{(WIDTH-8){1'b0}}, imm8};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_writes = !dec_illegal && op_writes_reg(dec_op);
  assign dec_flags  = !dec_illegal && (dec_op != OP_NOP);

  assign alu_busy     = (state == S_READ) || (state == S_EXEC);
  assign alu_opcode   = alu_busy ? dec_op : OP_NOP;
  assign alu_a        = alu_busy ? rd_val : '0;
  assign alu_b        = alu_busy ? dec_b  : '0;
  assign alu_carry_in = alu_busy && psr_q[PSR_C];

  // Preloads only happen in IDLE and writeback only in WB, so one port suffices.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state == S_WB) begin
      rf_we    = dec_writes;
      rf_waddr = rdest;
      rf_wdata = result_q;
    end else if (state == S_IDLE) begin
      rf_we    = ld_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= (state == S_WB);
      err_q  <= (state == S_WB) && dec_illegal;
      if (state == S_IDLE && in_valid && !ld_en) begin
        inst_q <= in_inst;
      end
      if (state == S_EXEC) begin
        result_q       <= alu_c;
        flags_q[PSR_C] <= alu_carry;
        flags_q[PSR_F] <= alu_flag;
        flags_q[PSR_L] <= alu_low;
        flags_q[PSR_N] <= alu_neg;
        flags_q[PSR_Z] <= alu_zero;
      end
      if (state == S_WB && dec_flags) begin
        psr_q <= flags_q;
      end
    end
  end

  assign psr  = psr_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a stand-in combinational ALU, a transaction-level
// reference model, directed scenarios and a randomized run.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_inst = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic        alu_carry, alu_flag, alu_low, alu_neg, alu_zero;
  logic [4:0]  psr;
  logic        done, err;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .alu_c        (alu_c),
    .alu_carry    (alu_carry),
    .alu_flag     (alu_flag),
    .alu_low      (alu_low),
    .alu_neg      (alu_neg),
    .alu_zero     (alu_zero),
    .psr          (psr),
    .done         (done),
    .err          (err),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  localparam logic [7:0] LEGAL_OPS [21] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B, 8'h0F,
    8'h80, 8'h81, 8'h84, 8'h86, 8'h8C, 8'h50, 8'h60, 8'h70, 8'h90, 8'hB0
  };

  // Stand-in ALU: returns {result, C, F, L, N, Z}.
  function automatic logic [20:0] aluFn(input logic [7:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] c;
    logic        cf, ff, lf;
    s = '0; c = '0; cf = 1'b0; ff = 1'b0; lf = 1'b0;
    case (op)
      8'h01, 8'h08: c = a & b;
      8'h02:        c = a | b;
      8'h03:        c = a ^ b;
      8'h0F:        c = ~a;
      8'h05, 8'h50: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[15:0]; cf = s[16];
        ff = (a[15] == b[15]) && (c[15] != a[15]);
      end
      8'h06, 8'h60: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[15:0]; cf = s[16];
      end
      8'h07, 8'h70: begin
        s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        c = s[15:0]; cf = s[16];
      end
      8'h09, 8'h0B, 8'h90, 8'hB0: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[15:0]; cf = s[16];
        ff = (a[15] != b[15]) && (c[15] != a[15]);
        lf = (a < b);
      end
      8'h80, 8'h84: c = a << b[3:0];
      8'h81, 8'h8C: c = a >> b[3:0];
      8'h86:        c = 16'($signed(a) >>> b[3:0]);
      default:      c = '0;
    endcase
    return {c, cf, ff, lf, c[15], (c == 16'h0000)};
  endfunction

  assign {alu_c, alu_carry, alu_flag, alu_low, alu_neg, alu_zero} =
    aluFn(alu_opcode, alu_a, alu_b, alu_carry_in);

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] b;
    logic        legal;
    logic        wr;
    logic        fl;
  } dec_t;

  // Reference decode: legality is membership of the resulting opcode in the ISA list.
  function automatic dec_t refDecode(input logic [15:0] inst, input logic [15:0] rsrcVal);
    dec_t d;
    logic [3:0] cls;
    cls = inst[15:12];
    d.op = (cls == 4'h0 || cls == 4'h8) ? {cls, inst[7:4]} : {cls, 4'h0};
    d.legal = d.op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h08,
                           8'h09, 8'h0B, 8'h0F, 8'h80, 8'h81, 8'h84, 8'h86, 8'h8C,
                           8'h50, 8'h60, 8'h70, 8'h90, 8'hB0};
    case (d.op)
      8'h50, 8'h90, 8'hB0: d.b = {{8{inst[7]}}, inst[7:0]};
      8'h60, 8'h70:        d.b = {8'h00, inst[7:0]};
      8'h80, 8'h81:        d.b = {12'h000, inst[3:0]};
      default:             d.b = rsrcVal;
    endcase
    if (!d.legal) d.op = 8'h00;
    d.wr = d.legal && !(d.op inside {8'h00, 8'h0B, 8'hB0, 8'h08});
    d.fl = d.legal && (d.op != 8'h00);
    return d;
  endfunction

  // Reference model: step counts cycles since acceptance (0 = waiting for work).
  int          step = 0;
  logic [15:0] mInst = '0;
  logic [15:0] mregs [16];
  logic [4:0]  mpsr = '0;
  logic        mDone = 1'b0;
  logic        mErr = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    dec_t d;
    logic [20:0] r;
    if (!rst_n) begin
      step = 0; mInst = '0; mpsr = '0; mDone = 1'b0; mErr = 1'b0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
    end else begin
      mDone = 1'b0;
      mErr  = 1'b0;
      if (step == 0) begin
        if (ld_en) mregs[ld_addr] = ld_data;
        else if (in_valid) begin
          mInst = in_inst;
          step  = 1;
        end
      end else if (step < 3) begin
        step = step + 1;
      end else begin
        d = refDecode(mInst, mregs[mInst[3:0]]);
        r = aluFn(d.op, mregs[mInst[11:8]], d.b, mpsr[4]);
        if (d.wr) mregs[mInst[11:8]] = r[20:5];
        if (d.fl) mpsr = r[4:0];
        mDone = 1'b1;
        mErr  = !d.legal;
        step  = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    dec_t d;
    logic busy;
    busy = (step == 1) || (step == 2);
    d = refDecode(mInst, mregs[mInst[3:0]]);
    checkOutput("in_ready", 32'(in_ready), 32'((step == 0) && !ld_en));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("err", 32'(err), 32'(mErr));
    checkOutput("psr", 32'(psr), 32'(mpsr));
    checkOutput("dbg_data", 32'(dbg_data), 32'(mregs[dbg_addr]));
    if (busy) begin
      checkOutput("alu_opcode", 32'(alu_opcode), 32'(d.op));
      checkOutput("alu_a", 32'(alu_a), 32'(mregs[mInst[11:8]]));
      checkOutput("alu_carry_in", 32'(alu_carry_in), 32'(mpsr[4]));
      if (d.legal) checkOutput("alu_b", 32'(alu_b), 32'(d.b));
    end else begin
      checkOutput("alu_opcode_idle", 32'(alu_opcode), 32'h0);
      checkOutput("alu_a_idle", 32'(alu_a), 32'h0);
      checkOutput("alu_b_idle", 32'(alu_b), 32'h0);
      checkOutput("alu_cin_idle", 32'(alu_carry_in), 32'h0);
    end
  end

  task automatic preload(input logic [3:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Issues one instruction and checks done arrives on the 4th cycle after acceptance.
  task automatic applyStimulus(input logic [15:0] inst, input string name, output logic errSeen);
    int n;
    bit seen;
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = inst;
    @(posedge clk); #1;
    in_valid = 1'b0; in_inst = 16'($urandom);
    n = 0; seen = 1'b0; errSeen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        errSeen = err;
      end
    end
    checkOutput({name, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic checkReg(input logic [3:0] addr, input logic [15:0] exp, input string name);
    @(posedge clk); #1;
    dbg_addr = addr;
    @(negedge clk);
    checkOutput(name, 32'(dbg_data), 32'(exp));
    checkOutput({name, "_model"}, 32'(mregs[addr]), 32'(exp));
  endtask

  function automatic logic [15:0] genInst();
    logic [7:0]  op;
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 9) < 7) begin
      op = LEGAL_OPS[$urandom_range(0, 20)];
      if (op[7:4] == 4'h0 || op[7:4] == 4'h8) w = {op[7:4], w[11:8], op[3:0], w[3:0]};
      else w = {op[7:4], w[11:0]};
    end
    return w;
  endfunction

  initial begin
    logic e;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    checkOutput("rst_psr", 32'(psr), 32'h0);
    checkOutput("rst_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_opcode", 32'(alu_opcode), 32'h0);

    preload(4'd1, 16'h7FFF);
    preload(4'd2, 16'h0001);
    applyStimulus(16'h0152, "add", e);
    checkReg(4'd1, 16'h8000, "add_r1");
    checkOutput("add_psr", 32'(psr), 32'(5'b01010));

    preload(4'd3, 16'hFFFF);
    preload(4'd4, 16'h0001);
    applyStimulus(16'h0364, "addu", e);
    checkReg(4'd3, 16'h0000, "addu_r3");
    checkOutput("addu_c", 32'(psr[4]), 32'h1);
    preload(4'd5, 16'h0000);
    preload(4'd6, 16'h0000);
    applyStimulus(16'h0576, "addcu", e);
    checkReg(4'd5, 16'h0001, "addcu_r5");
    checkOutput("addcu_c", 32'(psr[4]), 32'h0);

    preload(4'd7, 16'h0005);
    applyStimulus(16'h97FF, "subi", e);
    checkReg(4'd7, 16'h0006, "subi_r7");
    applyStimulus(16'hB706, "cmpi", e);
    checkReg(4'd7, 16'h0006, "cmpi_r7");
    checkOutput("cmpi_z", 32'(psr[0]), 32'h1);

    preload(4'd8, 16'h8000);
    preload(4'd9, 16'h0004);
    applyStimulus(16'h8869, "arsh", e);
    checkReg(4'd8, 16'hF800, "arsh_r8");
    applyStimulus(16'h8801, "lshi", e);
    checkReg(4'd8, 16'hF000, "lshi_r8");
    checkOutput("lshi_psr", 32'(psr), 32'(5'b00010));

    applyStimulus(16'hF123, "illegal", e);
    checkOutput("illegal_err", 32'(e), 32'h1);
    checkOutput("illegal_psr", 32'(psr), 32'(5'b00010));
    checkReg(4'd1, 16'h8000, "illegal_r1");

    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 4'd10; ld_data = 16'h1234;
    in_valid = 1'b1; in_inst = 16'h0152;
    repeat (3) begin
      @(negedge clk);
      checkOutput("ld_block_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    ld_en = 1'b0; in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("ld_block_nodone", 32'(done), 32'h0);
    end
    checkReg(4'd10, 16'h1234, "ld_r10");
    checkReg(4'd1, 16'h8000, "ld_r1");

    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = 16'h0152;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("exec_opcode", 32'(alu_opcode), 32'h05);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_psr", 32'(psr), 32'h0);
    checkOutput("abort_ready", 32'(in_ready), 32'h1);
    checkOutput("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("abort_nodone", 32'(done), 32'h0);
    end
    checkReg(4'd1, 16'h0000, "abort_r1");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_n    = ($urandom_range(0, 399) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_inst  = genInst();
      ld_en    = ($urandom_range(0, 6) == 0);
      ld_addr  = 4'($urandom);
      ld_data  = 16'($urandom);
      dbg_addr = 4'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; ld_en = 1'b0;
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
